mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the IF stage (instruction fetch) and the MEM stage (load/store).
- Sequences every memory transaction with a req/ack handshake and absorbs variable memory latency.
- Generates the stall signals that freeze PC/IF_ID (fetch side) and the full pipeline (data side) until the access completes.
- Sits between the pipeline's fetch/data interfaces and the external memory model.

Parameters:
- TIMEOUT, 255: max cycles m_req may wait for m_ack before abort; 0 disables the timeout; legal range 0..65535.
- ADDR_W, 32: address width for if_addr, d_addr, m_addr.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held stable with if_addr until if_ready.
- if_addr  in  ADDR_W  fetch address (PC).
- if_rdata  out  32  fetched instruction; valid when if_ready=1.
- if_ready  out  1  one-cycle completion pulse for fetch.
- if_stall  out  1  combinational: if_req & ~if_ready.
- d_read  in  1  load request (MemRead).
- d_write  in  1  store request (MemWrite).
- d_addr  in  ADDR_W  data address.
- d_wdata  in  32  store data.
- d_funct3  in  3  access size/sign, passed to memory unchanged.
- d_rdata  out  32  load data; valid when d_ready=1.
- d_ready  out  1  one-cycle completion pulse for data.
- d_stall  out  1  combinational: (d_read|d_write) & ~d_ready.
- bus_err  out  1  pulses with if_ready/d_ready when the access timed out.
- m_req  out  1  memory request, registered.
- m_we  out  1  1=write, 0=read, registered.
- m_addr  out  ADDR_W  registered.
- m_wdata  out  32  registered.
- m_funct3  out  3  registered; 3'b010 (word) for fetches.
- m_rdata  in  32  memory read data; valid with m_ack.
- m_ack  in  1  one-cycle completion from memory.

Behaviour:
- Reset (synchronous): state=IDLE, m_req=0, m_we=0, m_addr/m_wdata/m_funct3=0, if_rdata/d_rdata=0, if_ready/d_ready/bus_err=0, last_was_d=0, timeout counter=0.
- Reset mid-transaction: m_req drops at that edge. A later m_ack is ignored.
- States:
  - IDLE: no request pending. Goes to BUSY_I or BUSY_D on a pending request, after arbitration.
  - BUSY_I / BUSY_D: m_req held with registered command. On m_ack, capture m_rdata into the owner's rdata, clear m_req, go to DONE_I / DONE_D. Non-owner rdata is unchanged.
  - DONE_I / DONE_D: owner's ready is 1 for exactly this cycle, then IDLE. No grant is made in DONE, so the still-asserted request cannot be reissued.
- Arbitration in IDLE: data pending = d_read|d_write.
  - Data wins if pending and (~if_req or ~last_was_d).
  - Otherwise fetch wins if if_req.
  - last_was_d is updated at each grant (1 for data, 0 for fetch).
  - Result: data has priority, but strictly alternates with fetch when both stay pending, so there is no starvation.
- Grant latches the command:
  - Fetch: m_we=0, m_funct3=3'b010, m_addr=if_addr.
  - Data: m_we=d_write, m_addr=d_addr, m_wdata=d_wdata, m_funct3=d_funct3.
- d_read and d_write both high: treated as a write. The write's d_ready still pulses; d_rdata is unchanged.
- Latency: request sampled in IDLE at edge N → m_req=1 after edge N → if m_ack arrives in that cycle, ready=1 after edge N+1. Minimum is 2 cycles request-to-ready; each extra memory wait cycle adds 1.
- Timeout (TIMEOUT>0):
  - The counter clears at grant and increments each BUSY cycle without m_ack.
  - When the counter reaches TIMEOUT with no m_ack: drop m_req, load the owner's rdata with 32'h00000013 (NOP) for a fetch or 0 for data, enter DONE with bus_err=1.
  - m_ack in the same cycle as expiry wins: normal completion, no error.
- m_ack outside BUSY states: ignored.
- Request withdrawn during BUSY: the transaction completes anyway, and the ready pulse is still generated.
- Stalls are combinational from the request and ready signals. They deassert in the DONE cycle so the pipeline advances on that edge.

Test Plan:
- Reset, then fetch only: if_req=1, if_addr=0x40, memory acks in the cycle after m_req with 0x00500093 → m_addr=0x40, m_we=0; if_ready pulses 2 cycles after the request with if_rdata=0x00500093; if_stall high for 2 cycles.
- Simultaneous if_req and d_read (addr 0x100, funct3 010, mem wait 3 cycles) from reset → data granted first (last_was_d=0); then fetch granted after DONE_D; both readies pulse exactly once.
- Both requests held continuously for 6 transactions → grant order D,I,D,I,D,I; no fetch waits more than one data access.
- Store: d_write=1, d_addr=0x200, d_wdata=0xDEADBEEF, d_funct3=000 → m_we=1 and m_wdata/m_funct3 match; d_rdata unchanged; d_ready single pulse.
- TIMEOUT=4, memory never acks a fetch → m_req drops after 4 BUSY cycles; if_ready=1, bus_err=1, if_rdata=0x00000013; a next request is served normally.
- Reset asserted in BUSY_D with m_ack arriving 1 cycle later → all outputs at reset values; no ready pulse; the stray m_ack is ignored.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store,
// sequencing each access with a req/ack handshake and a bounded wait.
`timescale 1ns/1ps

module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  // fetch side
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  output logic              if_stall,
  // data side
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [2:0]        d_funct3,
  output logic [31:0]       d_rdata,
  output logic              d_ready,
  output logic              d_stall,
  output logic              bus_err,
  // memory side
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  output logic [2:0]        m_funct3,
  input  logic [31:0]       m_rdata,
  input  logic              m_ack
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BUSY_I,
    S_BUSY_D,
    S_DONE_I,
    S_DONE_D
  } state_e;

  localparam logic [31:0] NOP_INSN   = 32'h0000_0013;
  localparam logic [2:0]  FUNCT3_WORD = 3'b010;
  localparam logic [16:0] TMO_LIMIT  = 17'(TIMEOUT);
  localparam bit          TMO_EN     = (TIMEOUT != 0);

  state_e              state_q,    state_d;
  logic                m_req_q,    m_req_d;
  logic                m_we_q,     m_we_d;
  logic [ADDR_W-1:0]   m_addr_q,   m_addr_d;
  logic [31:0]         m_wdata_q,  m_wdata_d;
  logic [2:0]          m_funct3_q, m_funct3_d;
  logic [31:0]         if_rdata_q, if_rdata_d;
  logic [31:0]         d_rdata_q,  d_rdata_d;
  logic                if_ready_q, if_ready_d;
  logic                d_ready_q,  d_ready_d;
  logic                bus_err_q,  bus_err_d;
  logic                last_was_d_q, last_was_d_d;
  logic [15:0]         tmo_cnt_q,  tmo_cnt_d;

  logic d_pend;
  logic grant_d;
  logic grant_i;
  logic tmo_expire;

  assign d_pend  = d_read | d_write;
  // Data wins unless the previous grant was also data and fetch is waiting.
  assign grant_d = d_pend & (~if_req | ~last_was_d_q);
  assign grant_i = if_req & ~grant_d;

  assign tmo_expire = TMO_EN && (({1'b0, tmo_cnt_q} + 17'd1) == TMO_LIMIT);

  always_comb begin
    // NOTE: every signal gets a default up front so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d      = state_q;
    m_req_d      = m_req_q;
    m_we_d       = m_we_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    m_funct3_d   = m_funct3_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    if_ready_d   = 1'b0;
    d_ready_d    = 1'b0;
    bus_err_d    = 1'b0;
    last_was_d_d = last_was_d_q;
    tmo_cnt_d    = tmo_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (grant_d) begin
          state_d      = S_BUSY_D;
          m_req_d      = 1'b1;
          m_we_d       = d_write;
          m_addr_d     = d_addr;
          m_wdata_d    = d_wdata;
          m_funct3_d   = d_funct3;
          last_was_d_d = 1'b1;
          tmo_cnt_d    = '0;
        end else if (grant_i) begin
          state_d      = S_BUSY_I;
          m_req_d      = 1'b1;
          m_we_d       = 1'b0;
          m_addr_d     = if_addr;
          m_funct3_d   = FUNCT3_WORD;
          last_was_d_d = 1'b0;
          tmo_cnt_d    = '0;
        end
      end

      S_BUSY_I: begin
        if (m_ack) begin
          state_d    = S_DONE_I;
          m_req_d    = 1'b0;
          if_rdata_d = m_rdata;
          if_ready_d = 1'b1;
        end else if (tmo_expire) begin
          state_d    = S_DONE_I;
          m_req_d    = 1'b0;
          if_rdata_d = NOP_INSN;
          if_ready_d = 1'b1;
          bus_err_d  = 1'b1;
        end else begin
          tmo_cnt_d  = tmo_cnt_q + 16'd1;
        end
      end

      S_BUSY_D: begin
        if (m_ack) begin
          state_d   = S_DONE_D;
          m_req_d   = 1'b0;
          // A write (including read+write) leaves the load data untouched.
          if (!m_we_q) d_rdata_d = m_rdata;
          d_ready_d = 1'b1;
        end else if (tmo_expire) begin
          state_d   = S_DONE_D;
          m_req_d   = 1'b0;
          d_rdata_d = '0;
          d_ready_d = 1'b1;
          bus_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end

      // Requests are still asserted during DONE; returning to IDLE without a
      // grant keeps the completed access from being issued twice.
      S_DONE_I, S_DONE_D: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples
    // the values from before this edge, independent of statement order.
    if (reset) begin
      state_q      <= S_IDLE;
      m_req_q      <= 1'b0;
      m_we_q       <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      m_funct3_q   <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      if_ready_q   <= 1'b0;
      d_ready_q    <= 1'b0;
      bus_err_q    <= 1'b0;
      last_was_d_q <= 1'b0;
      tmo_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      m_req_q      <= m_req_d;
      m_we_q       <= m_we_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      m_funct3_q   <= m_funct3_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      if_ready_q   <= if_ready_d;
      d_ready_q    <= d_ready_d;
      bus_err_q    <= bus_err_d;
      last_was_d_q <= last_was_d_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  assign m_req    = m_req_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign m_funct3 = m_funct3_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign if_ready = if_ready_q;
  assign d_ready  = d_ready_q;
  assign bus_err  = bus_err_q;

  // Stalls drop in the DONE cycle so the pipeline advances on the next edge.
  assign if_stall = if_req & ~if_ready_q;
  assign d_stall  = d_pend & ~d_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: memory responder with programmable wait,
// pulse monitors and hand-computed expectations for each scenario.
`timescale 1ns/1ps

module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        if_stall;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [2:0]  d_funct3;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        d_stall;
  logic        bus_err;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [2:0]  m_funct3;
  logic [31:0] m_rdata;
  logic        m_ack;

  mem_port_arbiter #(.TIMEOUT(4), .ADDR_W(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ready (if_ready),
    .if_stall (if_stall),
    .d_read   (d_read),
    .d_write  (d_write),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_funct3 (d_funct3),
    .d_rdata  (d_rdata),
    .d_ready  (d_ready),
    .d_stall  (d_stall),
    .bus_err  (bus_err),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_funct3 (m_funct3),
    .m_rdata  (m_rdata),
    .m_ack    (m_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory responder: acks ack_wait cycles after m_req rises (-1 = never).
  int          ack_wait = 0;
  int          busy_cnt = 0;
  logic [31:0] grant_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h40) return 32'h0050_0093;
    return a ^ 32'h1357_9BDF;
  endfunction

  initial begin
    m_ack   = 1'b0;
    m_rdata = 32'hBAD0_BAD0;
    forever begin
      @(negedge clk);
      if (m_req) begin
        if (busy_cnt == 0) grant_log.push_back(m_addr);
        m_ack    = (ack_wait >= 0) && (busy_cnt == ack_wait);
        m_rdata  = m_ack ? mem_word(m_addr) : 32'hBAD0_BAD0;
        busy_cnt = busy_cnt + 1;
      end else begin
        busy_cnt = 0;
        m_ack    = 1'b0;
        m_rdata  = 32'hBAD0_BAD0;
      end
    end
  end

  // Pulse / cycle monitors.
  int if_pulses = 0;
  int d_pulses  = 0;
  int mreq_cyc  = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (if_ready) if_pulses++;
      if (d_ready)  d_pulses++;
      if (m_req)    mreq_cyc++;
    end
  end

  task automatic clear_counts();
    if_pulses = 0;
    d_pulses  = 0;
    mreq_cyc  = 0;
    grant_log.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    if_req  = 1'b0;
    d_read  = 1'b0;
    d_write = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Waits up to max negedges for a ready pulse; n = negedges taken, -1 on expiry.
  task automatic wait_rdy(input bit is_d, input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (is_d ? d_ready : if_ready) begin
        n = i;
        return;
      end
    end
    $display("FAIL wait_rdy: no %s ready within %0d cycles", is_d ? "data" : "fetch", max);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int done;
    reset    = 1'b1;
    if_req   = 1'b0;
    if_addr  = '0;
    d_read   = 1'b0;
    d_write  = 1'b0;
    d_addr   = '0;
    d_wdata  = '0;
    d_funct3 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_m_req",    32'(m_req),    32'd0);
    check("rst_m_addr",   m_addr,        32'd0);
    check("rst_if_rdata", if_rdata,      32'd0);
    check("rst_rdy_err",  {29'd0, if_ready, d_ready, bus_err}, 32'd0);

    // 1: lone fetch, memory acks in the first request cycle.
    @(negedge clk);
    clear_counts();
    ack_wait = 0;
    if_req   = 1'b1;
    if_addr  = 32'h40;
    #1 check("t1_stall_pre", 32'(if_stall), 32'd1);
    @(negedge clk);
    check("t1_m_req",    32'(m_req),    32'd1);
    check("t1_m_addr",   m_addr,        32'h40);
    check("t1_m_we",     32'(m_we),     32'd0);
    check("t1_m_funct3", 32'(m_funct3), 32'd2);
    check("t1_stall",    32'(if_stall), 32'd1);
    wait_rdy(1'b0, 8, n);
    check("t1_latency",  n + 1,         32'd2);
    check("t1_if_rdata", if_rdata,      32'h0050_0093);
    check("t1_bus_err",  32'(bus_err),  32'd0);
    check("t1_stall_done", 32'(if_stall), 32'd0);
    if_req = 1'b0;
    @(negedge clk);
    check("t1_ready_drop", 32'(if_ready), 32'd0);
    check("t1_if_pulses",  if_pulses,     32'd1);

    // 2: simultaneous fetch + load after reset, 3 memory wait cycles.
    do_reset();
    clear_counts();
    ack_wait = 3;
    if_req   = 1'b1;
    if_addr  = 32'h44;
    d_read   = 1'b1;
    d_addr   = 32'h100;
    d_funct3 = 3'b010;
    @(negedge clk);
    check("t2_first_addr", m_addr,        32'h100);
    check("t2_first_we",   32'(m_we),     32'd0);
    wait_rdy(1'b1, 10, n);
    check("t2_d_latency",  n + 1,         32'd5);
    check("t2_d_rdata",    d_rdata,       32'h1357_9ADF);
    check("t2_d_bus_err",  32'(bus_err),  32'd0);
    check("t2_if_stalled", 32'(if_stall), 32'd1);
    d_read = 1'b0;
    wait_rdy(1'b0, 12, n);
    check("t2_if_wait",    n,             32'd6);
    check("t2_if_rdata",   if_rdata,      32'h1357_9B9B);
    check("t2_d_rdata_kept", d_rdata,     32'h1357_9ADF);
    if_req = 1'b0;
    @(negedge clk);
    check("t2_pulses", {if_pulses[15:0], d_pulses[15:0]}, {16'd1, 16'd1});

    // 3: both held for six transactions -> strict alternation D,I,D,I,D,I.
    do_reset();
    clear_counts();
    ack_wait = 0;
    if_req   = 1'b1;
    if_addr  = 32'h44;
    d_read   = 1'b1;
    d_addr   = 32'h100;
    done     = 0;
    for (int i = 0; i < 40 && done < 6; i++) begin
      @(negedge clk);
      if (if_ready || d_ready) done++;
    end
    check("t3_done", done, 32'd6);
    if_req = 1'b0;
    d_read = 1'b0;
    @(negedge clk);
    check("t3_grants", grant_log.size(), 32'd6);
    for (int i = 0; i < 6; i++) begin
      logic [31:0] exp_a;
      exp_a = (i % 2 == 0) ? 32'h100 : 32'h44;
      check($sformatf("t3_grant%0d", i), (i < grant_log.size()) ? grant_log[i] : 32'hFFFF_FFFF, exp_a);
    end
    check("t3_pulses", {if_pulses[15:0], d_pulses[15:0]}, {16'd3, 16'd3});

    // 4: store, then read+write treated as a write; load data stays.
    clear_counts();
    ack_wait = 1;
    d_write  = 1'b1;
    d_addr   = 32'h200;
    d_wdata  = 32'hDEAD_BEEF;
    d_funct3 = 3'b000;
    @(negedge clk);
    check("t4_m_we",     32'(m_we),     32'd1);
    check("t4_m_addr",   m_addr,        32'h200);
    check("t4_m_wdata",  m_wdata,       32'hDEAD_BEEF);
    check("t4_m_funct3", 32'(m_funct3), 32'd0);
    check("t4_d_stall",  32'(d_stall),  32'd1);
    wait_rdy(1'b1, 6, n);
    check("t4_latency",  n + 1,         32'd3);
    check("t4_d_rdata",  d_rdata,       32'h1357_9ADF);
    check("t4_stall_done", 32'(d_stall), 32'd0);
    d_write = 1'b0;
    @(negedge clk);
    d_read   = 1'b1;
    d_write  = 1'b1;
    d_addr   = 32'h204;
    d_wdata  = 32'h0BAD_F00D;
    d_funct3 = 3'b001;
    @(negedge clk);
    check("t4_rw_we",    32'(m_we),     32'd1);
    check("t4_rw_wdata", m_wdata,       32'h0BAD_F00D);
    wait_rdy(1'b1, 6, n);
    check("t4_rw_rdata", d_rdata,       32'h1357_9ADF);
    d_read  = 1'b0;
    d_write = 1'b0;
    @(negedge clk);
    check("t4_d_pulses", d_pulses,      32'd2);

    // 5: fetch never acked -> timeout after 4 BUSY cycles, then normal load.
    clear_counts();
    ack_wait = -1;
    if_req   = 1'b1;
    if_addr  = 32'h300;
    wait_rdy(1'b0, 12, n);
    check("t5_latency",  n,             32'd5);
    check("t5_mreq_cyc", mreq_cyc,      32'd4);
    check("t5_bus_err",  32'(bus_err),  32'd1);
    check("t5_if_rdata", if_rdata,      32'h0000_0013);
    check("t5_m_req",    32'(m_req),    32'd0);
    if_req = 1'b0;
    @(negedge clk);
    check("t5_err_drop", 32'(bus_err),  32'd0);
    ack_wait = 0;
    d_read   = 1'b1;
    d_addr   = 32'h104;
    wait_rdy(1'b1, 6, n);
    check("t5_next_lat",   n,           32'd2);
    check("t5_next_rdata", d_rdata,     32'h1357_9ADB);
    check("t5_next_err",   32'(bus_err), 32'd0);
    d_read = 1'b0;
    @(negedge clk);

    // 6: reset while BUSY_D, stray ack one cycle later.
    clear_counts();
    ack_wait = -1;
    d_read   = 1'b1;
    d_addr   = 32'h108;
    @(negedge clk);
    check("t6_busy", 32'(m_req), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("t6_rst_m_req",  32'(m_req), 32'd0);
    check("t6_rst_m_addr", m_addr,     32'd0);
    d_read = 1'b0;
    reset  = 1'b0;
    #1 m_ack = 1'b1;
    @(negedge clk);
    check("t6_no_ready", {30'd0, d_ready, if_ready}, 32'd0);
    check("t6_m_req",    32'(m_req),  32'd0);
    repeat (3) @(negedge clk);
    check("t6_d_rdata",  d_rdata,     32'd0);
    check("t6_bus_err",  32'(bus_err), 32'd0);
    check("t6_pulses",   d_pulses + if_pulses, 32'd0);
    check("t6_idle_req", 32'(m_req),  32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
